arb_rr_2: RTL and testbench

Two-requester round-robin arbiter sharing a single resource between requesters 0 and 1. It produces one-hot grants through a `decoder_2to1` instance: `sel` is the owner index and `en` is the grant-active flag. It guarantees a dead cycle between owners and preempts an owner that holds the resource too long while the other requester waits. It sits between requester logic and any shared datapath whose enable lines are decoded from a 1-bit select.

---
 rtl/arb_pkg.sv | 36 +++
 rtl/arb_rr_2_decoder_2to1.sv | 22 ++
 rtl/arb_rr_2.sv | 152 +++++++++++++++
 tb/tb_arb_rr_2.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// ----------------------------------------------------------------------------
// arb_pkg
//
// Purpose : shared types and helpers for the two-requester round-robin
//           arbiter (arb_rr_2) and its bench.
// Contents:
//   arb_state_t : FSM state encoding (IDLE, GRANT, RELEASE)
//   ARB_N       : number of requesters
//   arb_pick    : round-robin winner selection for a non-empty request vector
// ----------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam int ARB_N = 2;

    // Winner among the active requesters.
    // A lone requester always wins. When both are active, prio breaks the tie.
    // The result is meaningless when req is all zeros, so the caller must
    // qualify it with |req.
    function automatic logic arb_pick(input logic [ARB_N-1:0] req,
                                      input logic             prio);
        logic w_pick;
        if (req[0] && req[1]) begin
            w_pick = prio;
        end else begin
            w_pick = req[1];
        end
        return w_pick;
    endfunction

endpackage

// File: rtl/arb_rr_2_decoder_2to1.sv
// ----------------------------------------------------------------------------
// decoder_2to1
//
// Purpose : 1-bit select to one-hot decoder with a global enable. Produces
//           the arbiter's grant lines from the owner index.
// Ports   :
//   sel : in  1  index of the line to drive
//   en  : in  1  when low, both outputs are low
//   y0  : out 1  high when en && sel == 0
//   y1  : out 1  high when en && sel == 1
// ----------------------------------------------------------------------------
module decoder_2to1 (
    input  logic sel,
    input  logic en,
    output logic y0,
    output logic y1
);

    assign y0 = en & ~sel;
    assign y1 = en &  sel;

endmodule

// File: rtl/arb_rr_2.sv
// ----------------------------------------------------------------------------
// arb_rr_2
//
// Purpose : round-robin arbiter for two requesters sharing one resource.
//           Grants are one-hot, there is always one dead cycle between
//           owners, and an owner that holds the resource for HOLD_MAX
//           cycles while the other requester waits is forced off.
//
// Handshake: there is no valid/ready pair here. req is a level: a requester
//           keeps its bit high for as long as it wants the resource. A grant
//           is visible in the cycle after the edge that sampled the request
//           and lasts until an exit condition is sampled. rel is only looked
//           at while a grant is active and is ignored otherwise.
//
// Parameters:
//   HOLD_MAX : contended grant length limit in cycles (>= 1)
//   CW       : hold-counter width, derived from HOLD_MAX
//
// Ports   :
//   clk       : in  1  rising-edge clock
//   rst       : in  1  asynchronous active-high reset
//   req       : in  2  request vector, bit i is requester i
//   rel       : in  1  owner's release strobe
//   gnt0      : out 1  grant to requester 0
//   gnt1      : out 1  grant to requester 1
//   owner     : out 1  current or most recent owner
//   busy      : out 1  state is not IDLE
//   preempt   : out 1  one-cycle pulse during RELEASE after a timeout exit
//   dbg_state : out 2  FSM state, for observation only
// ----------------------------------------------------------------------------
module arb_rr_2
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 8,
    parameter int CW       = $clog2(HOLD_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ARB_N-1:0] req,
    input  logic             rel,
    output logic             gnt0,
    output logic             gnt1,
    output logic             owner,
    output logic             busy,
    output logic             preempt,
    output arb_state_t       dbg_state
);

    localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    arb_state_t      r_state;
    logic            r_owner;
    logic            r_prio;
    logic [CW-1:0]   r_cnt;
    logic            r_preempt;

    // ------------------------------------------------------------------
    // Combinational decisions
    // ------------------------------------------------------------------
    logic            w_any_req;
    logic            w_winner;
    logic            w_other;
    logic            w_req_own;
    logic            w_req_oth;
    logic            w_timeout;
    logic            w_exit;
    logic            w_grant_en;

    assign w_any_req = |req;
    assign w_winner  = arb_pick(req, r_prio);
    assign w_other   = ~r_owner;
    assign w_req_own = req[r_owner];
    assign w_req_oth = req[w_other];

    // Timeout only matters when someone is actually waiting; without
    // contention the owner may keep the resource indefinitely.
    assign w_timeout = (r_cnt == CNT_MAX) && w_req_oth;
    assign w_exit    = rel || !w_req_own || w_timeout;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_owner   <= 1'b0;
            r_prio    <= 1'b0;
            r_cnt     <= '0;
            r_preempt <= 1'b0;
        end else begin
            // preempt is a pulse: it only survives the cycle it is set for.
            r_preempt <= 1'b0;

            case (r_state)
                IDLE, RELEASE: begin
                    // RELEASE arbitrates exactly like IDLE. Because prio was
                    // flipped away from the previous owner on exit, that
                    // owner only wins again when the other side is quiet.
                    if (w_any_req) begin
                        r_state <= GRANT;
                        r_owner <= w_winner;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= IDLE;
                    end
                end

                GRANT: begin
                    if (w_exit) begin
                        r_state   <= RELEASE;
                        r_prio    <= w_other;
                        // Flag a preemption only when the timeout was the
                        // sole reason for leaving; a voluntary release or a
                        // dropped request on the same edge takes precedence.
                        r_preempt <= w_timeout && !rel && w_req_own;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Grant decode: registered state, combinational decode, no extra flop,
    // so an asynchronous reset clears the grants immediately.
    // ------------------------------------------------------------------
    assign w_grant_en = (r_state == GRANT);

    decoder_2to1 u_dec (
        .sel (r_owner),
        .en  (w_grant_en),
        .y0  (gnt0),
        .y1  (gnt1)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign owner     = r_owner;
    assign busy      = (r_state != IDLE);
    assign preempt   = r_preempt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_arb_rr_2.sv
// ----------------------------------------------------------------------------
// tb_arb_rr_2
//
// Directed bench for arb_rr_2 with HOLD_MAX = 8. The driver applies one
// request/release vector per cycle on the falling edge and queues the
// hand-computed output word expected after the following rising edge. A
// monitor pops that word 1 ns after each rising edge and compares it.
// Output word layout: {busy, gnt1, gnt0, owner, preempt}.
// ----------------------------------------------------------------------------
module tb_arb_rr_2;
    import arb_pkg::*;

    localparam int W = 5;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic       rel = 1'b0;

    logic       gnt0;
    logic       gnt1;
    logic       owner;
    logic       busy;
    logic       preempt;
    arb_state_t dbg_state;

    always #5 clk = ~clk;

    arb_rr_2 #(.HOLD_MAX(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .rel       (rel),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .owner     (owner),
        .busy      (busy),
        .preempt   (preempt),
        .dbg_state (dbg_state)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc_idx  = 0;
    logic [W-1:0] mon_exp;
    logic [W-1:0] mon_act;

    function automatic logic [W-1:0] ev(input logic b, input logic g1,
                                        input logic g0, input logic own,
                                        input logic pre);
        return {b, g1, g0, own, pre};
    endfunction

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    task automatic step(input logic [1:0] r, input logic rl, input logic [W-1:0] e);
        @(negedge clk);
        req = r;
        rel = rl;
        exp_q.push_back(e);
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {busy, gnt1, gnt0, owner, preempt};
            n_checks++;
            cyc_idx++;
            if (mon_act !== mon_exp) begin
                n_errors++;
                $display("FAIL cycle_%0d: busy/gnt1/gnt0/owner/preempt got %b expected %b",
                         cyc_idx, mon_act, mon_exp);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        repeat (3) @(negedge clk);
        check1("reset_gnt0",    gnt0,    1'b0);
        check1("reset_gnt1",    gnt1,    1'b0);
        check1("reset_busy",    busy,    1'b0);
        check1("reset_owner",   owner,   1'b0);
        check1("reset_preempt", preempt, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Single requester, release strobe on the fourth edge
        step(2'b01, 1'b0, ev(1, 0, 1, 0, 0));
        step(2'b01, 1'b0, ev(1, 0, 1, 0, 0));
        step(2'b01, 1'b0, ev(1, 0, 1, 0, 0));
        step(2'b01, 1'b1, ev(1, 0, 0, 0, 0));
        step(2'b00, 1'b0, ev(0, 0, 0, 0, 0));
        step(2'b00, 1'b0, ev(0, 0, 0, 0, 0));

        // Both requesting, rel every third grant cycle: prio is now 1
        for (int k = 0; k < 3; k++) begin
            logic own_k;
            own_k = (k % 2 == 0) ? 1'b1 : 1'b0;
            step(2'b11, 1'b0, ev(1, own_k, ~own_k, own_k, 0));
            step(2'b11, 1'b0, ev(1, own_k, ~own_k, own_k, 0));
            step(2'b11, 1'b0, ev(1, own_k, ~own_k, own_k, 0));
            step(2'b11, 1'b1, ev(1, 0, 0, own_k, 0));
        end
        step(2'b00, 1'b0, ev(0, 0, 0, 1, 0));

        // Preemption: prio is 0, requester 0 alone first, then contention
        step(2'b01, 1'b0, ev(1, 0, 1, 0, 0));
        for (int k = 0; k < 7; k++) begin
            step(2'b11, 1'b0, ev(1, 0, 1, 0, 0));
        end
        step(2'b11, 1'b0, ev(1, 0, 0, 0, 1));
        step(2'b11, 1'b0, ev(1, 1, 0, 1, 0));

        // Owner 1 drops its request without rel
        step(2'b11, 1'b0, ev(1, 1, 0, 1, 0));
        step(2'b01, 1'b0, ev(1, 0, 0, 1, 0));
        // prio went back to 0, so the tie goes to requester 0
        step(2'b11, 1'b0, ev(1, 0, 1, 0, 0));

        // rel on the same edge as the timeout: plain release, no preempt
        for (int k = 0; k < 7; k++) begin
            step(2'b11, 1'b0, ev(1, 0, 1, 0, 0));
        end
        step(2'b11, 1'b1, ev(1, 0, 0, 0, 0));
        step(2'b11, 1'b0, ev(1, 1, 0, 1, 0));
        step(2'b11, 1'b0, ev(1, 1, 0, 1, 0));

        // Asynchronous reset while requester 1 holds the grant
        @(posedge clk);
        #3;
        check1("pre_reset_gnt1", gnt1, 1'b1);
        rst = 1'b1;
        #1;
        check1("async_rst_gnt0",    gnt0,    1'b0);
        check1("async_rst_gnt1",    gnt1,    1'b0);
        check1("async_rst_busy",    busy,    1'b0);
        check1("async_rst_preempt", preempt, 1'b0);
        req = 2'b11;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(ev(1, 0, 1, 0, 0));
        step(2'b00, 1'b0, ev(1, 0, 0, 0, 0));
        step(2'b00, 1'b0, ev(0, 0, 0, 0, 0));

        // Drain, bounded
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            @(posedge clk);
        end
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
